// File: rtl/main_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// main_ctrl_pkg
//   Shared definitions for the multicycle RV32I main control FSM:
//   - state_t      : FSM state encoding
//   - OPC_*        : RV32I major opcodes handled by the controller
//   - ALUOP_*      : alu_op encodings consumed by the ALU control decoder
//   - SRCA_* / SRCB_* / RES_* : datapath mux select encodings
//   - is_legal_opcode() : true for every opcode the FSM knows how to run
// ---------------------------------------------------------------------------
package main_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // alu_op encodings
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return (opc == OPC_R)     || (opc == OPC_I)      ||
               (opc == OPC_LOAD)  || (opc == OPC_STORE)  ||
               (opc == OPC_BRANCH)|| (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/main_ctrl_out_decode.sv
// ---------------------------------------------------------------------------
// main_ctrl_out_decode
//   Purely combinational output decoder of the main control FSM. Maps the
//   current state to datapath control signals; only pc_write/ir_write (fetch)
//   and instr_done (store) additionally depend on mem_ready.
// Ports:
//   state        in   state_t  current FSM state
//   mem_ready    in   1        memory completes current access this cycle
//   decode_done  in   1        retire in S_DECODE (unknown opcode treated as NOP)
//   pc_write .. halted  out    raw control outputs (reset gating is done by the top)
// ---------------------------------------------------------------------------
module main_ctrl_out_decode
    import main_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       decode_done,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       branch,
    output logic       instr_done,
    output logic       halted
);

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        branch     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 is computed and written straight back while the
                // instruction word is latched; both loads wait for memory.
                mem_read   = 1'b1;
                adr_src    = 1'b0;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch/jump target old PC + imm.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                instr_done = decode_done;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNC;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEMDATA;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2 drives zero; PC loads the target held in ALU out.
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                result_src = RES_ALUOUT;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // PC takes the target from ALU out while old PC + 4 is
                // computed for the link write in S_ALU_WB.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_main_ctrl
//   Multicycle RV32I main control FSM. Sequences fetch / decode / execute /
//   memory / writeback per instruction and handshakes with memory through
//   mem_ready. Produces alu_op for the ALU control decoder plus all datapath
//   mux selects and write enables.
//
// Parameters:
//   WAIT_LIMIT  max consecutive mem_ready=0 cycles tolerated in a memory
//               state before halting with mem_timeout; 0 = wait forever
// Configuration macro:
//   ILLEGAL_TRAP_EN  defined   : unknown opcode halts the FSM
//                    undefined : unknown opcode retires as a NOP in S_DECODE
// Ports:
//   clk, rst_n (sync, active-low)   opcode[6:0]  mem_ready
//   pc_write ir_write reg_write mem_read mem_write adr_src
//   alu_src_a[1:0] alu_src_b[1:0] alu_op[1:0] result_src[1:0] branch
//   instr_done (retire pulse)  halted  mem_timeout (sticky)
// ---------------------------------------------------------------------------
module multicycle_main_ctrl
    import main_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       branch,
    output logic       instr_done,
    output logic       halted,
    output logic       mem_timeout
);

    // Counter only has to reach WAIT_LIMIT-1; with WAIT_LIMIT=0 it just wraps.
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               mem_timeout_q;
    logic               in_mem_wait;
    logic               limit_hit;
    logic               decode_done;

    logic       raw_pc_write;
    logic       raw_ir_write;
    logic       raw_reg_write;
    logic       raw_mem_read;
    logic       raw_mem_write;
    logic       raw_adr_src;
    logic [1:0] raw_alu_src_a;
    logic [1:0] raw_alu_src_b;
    logic [1:0] raw_alu_op;
    logic [1:0] raw_result_src;
    logic       raw_branch;
    logic       raw_instr_done;
    logic       raw_halted;

    assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                         (state_q == S_MEM_WR);

    // A completing access in the limit cycle wins over the timeout because
    // limit_hit requires mem_ready=0.
    assign limit_hit = (WAIT_LIMIT > 0) && in_mem_wait && !mem_ready &&
                       (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));

`ifdef ILLEGAL_TRAP_EN
    assign decode_done = 1'b0;
`else
    assign decode_done = !is_legal_opcode(opcode);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (limit_hit) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (limit_hit)      state_d = S_HALT;
                else if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OPC_R:               state_d = S_EXEC_R;
                    OPC_I:               state_d = S_EXEC_I;
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_d = S_HALT;
`else
                    default:             state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (limit_hit)      state_d = S_HALT;
                else if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR: begin
                if (limit_hit)      state_d = S_HALT;
                else if (mem_ready) state_d = S_FETCH;
            end
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALU_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Wait counter counts stalled cycles of the current memory state only;
    // any completion or state change restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if (in_mem_wait && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Output decode
    main_ctrl_out_decode u_out_decode (
        .state       (state_q),
        .mem_ready   (mem_ready),
        .decode_done (decode_done),
        .pc_write    (raw_pc_write),
        .ir_write    (raw_ir_write),
        .reg_write   (raw_reg_write),
        .mem_read    (raw_mem_read),
        .mem_write   (raw_mem_write),
        .adr_src     (raw_adr_src),
        .alu_src_a   (raw_alu_src_a),
        .alu_src_b   (raw_alu_src_b),
        .alu_op      (raw_alu_op),
        .result_src  (raw_result_src),
        .branch      (raw_branch),
        .instr_done  (raw_instr_done),
        .halted      (raw_halted)
    );

    // Reset is asserted for the whole cycle: nothing may write while it is low.
    assign pc_write    = rst_n & raw_pc_write;
    assign ir_write    = rst_n & raw_ir_write;
    assign reg_write   = rst_n & raw_reg_write;
    assign mem_read    = rst_n & raw_mem_read;
    assign mem_write   = rst_n & raw_mem_write;
    assign adr_src     = rst_n & raw_adr_src;
    assign alu_src_a   = rst_n ? raw_alu_src_a  : 2'b00;
    assign alu_src_b   = rst_n ? raw_alu_src_b  : 2'b00;
    assign alu_op      = rst_n ? raw_alu_op     : 2'b00;
    assign result_src  = rst_n ? raw_result_src : 2'b00;
    assign branch      = rst_n & raw_branch;
    assign instr_done  = rst_n & raw_instr_done;
    assign halted      = rst_n & raw_halted;
    assign mem_timeout = rst_n & mem_timeout_q;

endmodule
